// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the time-shared ALU arbiter.
// Holds the sequencer states, ALU opcodes and NZCV flag bit positions.
package alu_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_OR  = 2'd3
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/ALU_32_Bit.sv
// 32-bit ADD/SUB/AND/OR unit with NZCV flags.
// C on SUB means "no borrow" (A >= B unsigned); logic ops clear C and V.
module ALU_32_Bit
  import alu_arb_pkg::*;
(
  input  logic [31:0] i_A,
  input  logic [31:0] i_B,
  input  alu_op_e     i_Op,
  output logic [31:0] o_Result,
  output logic [3:0]  o_Flags
);

  logic [32:0] sum;
  logic        carry;
  logic        ovf;

  always_comb begin
    sum      = '0;
    o_Result = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (i_Op)
      ALU_ADD: begin
        sum      = {1'b0, i_A} + {1'b0, i_B};
        o_Result = sum[31:0];
        carry    = sum[32];
        ovf      = (i_A[31] == i_B[31]) && (sum[31] != i_A[31]);
      end
      ALU_SUB: begin
        sum      = {1'b0, i_A} + {1'b0, ~i_B} + 33'd1;
        o_Result = sum[31:0];
        carry    = sum[32];
        ovf      = (i_A[31] != i_B[31]) && (sum[31] != i_A[31]);
      end
      ALU_AND: o_Result = i_A & i_B;
      ALU_OR:  o_Result = i_A | i_B;
      default: o_Result = '0;
    endcase
    o_Flags         = '0;
    o_Flags[FLAG_N] = o_Result[31];
    o_Flags[FLAG_Z] = (o_Result == 32'd0);
    o_Flags[FLAG_C] = carry;
    o_Flags[FLAG_V] = ovf;
  end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
// Requests are rotated down by the pointer, priority-picked, then rotated back.
module rr_grant #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0]         req_rot;
  logic [N-1:0]         first_rot;
  logic [N:0][IW-1:0]   idx_chain;

  assign req_rot = N'({req_i, req_i} >> ptr_i);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_pick
      if (gi == 0) begin : g_first
        assign first_rot[gi] = req_rot[0];
      end else begin : g_rest
        assign first_rot[gi] = req_rot[gi] & ~(|req_rot[gi-1:0]);
      end
    end
  endgenerate

  assign grant_o = N'(({first_rot, first_rot} << ptr_i) >> N);

  // One-hot to binary as an OR chain so every select stays constant.
  assign idx_chain[0] = '0;
  generate
    for (gi = 0; gi < N; gi++) begin : g_enc
      assign idx_chain[gi+1] = idx_chain[gi] | (grant_o[gi] ? IW'(gi) : '0);
    end
  endgenerate

  assign idx_o = idx_chain[N];
  assign any_o = |req_i;

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sequencer time-sharing one ALU_32_Bit between NUM_REQ requesters.
// One operation in flight: IDLE grant -> EXEC compute -> RESP hold until consumed.
module alu_share_arbiter
  import alu_arb_pkg::*;
#(
  parameter int         NUM_REQ   = 2,
  parameter logic [3:0] FLAGS_RST = 4'b0000
) (
  input  logic                     i_CLK,
  input  logic                     i_RST_N,
  input  logic [NUM_REQ-1:0]       i_ReqValid,
  output logic [NUM_REQ-1:0]       o_ReqReady,
  input  logic [NUM_REQ-1:0][31:0] i_ReqA,
  input  logic [NUM_REQ-1:0][31:0] i_ReqB,
  input  logic [NUM_REQ-1:0][1:0]  i_ReqOp,
  input  logic [NUM_REQ-1:0]       i_ReqSetFlags,
  output logic [NUM_REQ-1:0]       o_RspValid,
  input  logic [NUM_REQ-1:0]       i_RspReady,
  output logic [31:0]              o_RspResult,
  output logic [3:0]               o_RspFlags,
  output logic [3:0]               o_Flags
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  alu_op_e       op_q, op_d;
  logic          setf_q, setf_d;
  logic [31:0]   result_q, result_d;
  logic [3:0]    rsp_flags_q, rsp_flags_d;
  logic [3:0]    flags_q, flags_d;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;
  logic [31:0]        alu_result;
  logic [3:0]         alu_flags;
  logic [IW-1:0]      ptr_after_owner;

  rr_grant #(.N(NUM_REQ)) u_rr_grant (
    .req_i   (i_ReqValid),
    .ptr_i   (rr_ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  ALU_32_Bit u_alu (
    .i_A      (a_q),
    .i_B      (b_q),
    .i_Op     (op_q),
    .o_Result (alu_result),
    .o_Flags  (alu_flags)
  );

  assign ptr_after_owner = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + IW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    setf_d      = setf_q;
    result_d    = result_q;
    rsp_flags_d = rsp_flags_q;
    flags_d     = flags_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d = grant_idx;
          a_d     = i_ReqA[grant_idx];
          b_d     = i_ReqB[grant_idx];
          op_d    = alu_op_e'(i_ReqOp[grant_idx]);
          setf_d  = i_ReqSetFlags[grant_idx];
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d    = alu_result;
        rsp_flags_d = alu_flags;
        if (setf_q) flags_d = alu_flags;
        state_d     = RESP;
      end
      RESP: begin
        if (i_RspReady[owner_q]) begin
          rr_ptr_d = ptr_after_owner;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= ALU_ADD;
      setf_q      <= 1'b0;
      result_q    <= '0;
      rsp_flags_q <= '0;
      flags_q     <= FLAGS_RST;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      setf_q      <= setf_d;
      result_q    <= result_d;
      rsp_flags_q <= rsp_flags_d;
      flags_q     <= flags_d;
    end
  end

  assign o_ReqReady = (state_q == IDLE) ? grant : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rsp_valid
      assign o_RspValid[gi] = (state_q == RESP) && (owner_q == IW'(gi));
    end
  endgenerate

  assign o_RspResult = result_q;
  assign o_RspFlags  = rsp_flags_q;
  assign o_Flags     = flags_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: expected responses are queued at the
// request handshake and compared when the response is consumed.
module tb_alu_share_arbiter;
  import alu_arb_pkg::*;

  localparam int         NUM_REQ   = 2;
  localparam logic [3:0] FLAGS_RST = 4'b0000;
  localparam longint     SMAX      = 64'sd2147483647;
  localparam longint     SMIN      = -64'sd2147483648;

  logic                     i_CLK = 1'b0;
  logic                     i_RST_N = 1'b0;
  logic [NUM_REQ-1:0]       i_ReqValid = '0;
  logic [NUM_REQ-1:0]       o_ReqReady;
  logic [NUM_REQ-1:0][31:0] i_ReqA = '0;
  logic [NUM_REQ-1:0][31:0] i_ReqB = '0;
  logic [NUM_REQ-1:0][1:0]  i_ReqOp = '0;
  logic [NUM_REQ-1:0]       i_ReqSetFlags = '0;
  logic [NUM_REQ-1:0]       o_RspValid;
  logic [NUM_REQ-1:0]       i_RspReady = '0;
  logic [31:0]              o_RspResult;
  logic [3:0]               o_RspFlags;
  logic [3:0]               o_Flags;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .FLAGS_RST(FLAGS_RST)) dut (
    .i_CLK         (i_CLK),
    .i_RST_N       (i_RST_N),
    .i_ReqValid    (i_ReqValid),
    .o_ReqReady    (o_ReqReady),
    .i_ReqA        (i_ReqA),
    .i_ReqB        (i_ReqB),
    .i_ReqOp       (i_ReqOp),
    .i_ReqSetFlags (i_ReqSetFlags),
    .o_RspValid    (o_RspValid),
    .i_RspReady    (i_RspReady),
    .o_RspResult   (o_RspResult),
    .o_RspFlags    (o_RspFlags),
    .o_Flags       (o_Flags)
  );

  always #5 i_CLK = ~i_CLK;

  typedef struct {
    int          owner;
    logic [31:0] result;
    logic [3:0]  rflags;
    logic [3:0]  flags;
  } rsp_t;

  rsp_t       sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  logic [3:0] exp_flags = FLAGS_RST;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference ALU: returns {N,Z,C,V,result}, using wide arithmetic for C and V.
  function automatic logic [35:0] ref_alu(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        c, v;
    longint      sa, sb, sr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    r  = '0;
    case (op)
      2'd0: begin
        r  = a + b;
        c  = ({32'd0, a} + {32'd0, b}) > 64'hFFFF_FFFF;
        sr = sa + sb;
        v  = (sr > SMAX) || (sr < SMIN);
      end
      2'd1: begin
        r  = a - b;
        c  = (a >= b);
        sr = sa - sb;
        v  = (sr > SMAX) || (sr < SMIN);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  task automatic issue(input int r, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sf);
    i_ReqValid[r]    = 1'b1;
    i_ReqOp[r]       = op;
    i_ReqA[r]        = a;
    i_ReqB[r]        = b;
    i_ReqSetFlags[r] = sf;
  endtask

  // Called just after a rising edge with the requests already presented.
  task automatic serve(input int exp_owner, input int hold);
    rsp_t        e;
    logic [35:0] m;
    @(negedge i_CLK);
    check_eq("grant", o_ReqReady, onehot(exp_owner));
    m = ref_alu(i_ReqOp[exp_owner], i_ReqA[exp_owner], i_ReqB[exp_owner]);
    if (i_ReqSetFlags[exp_owner]) exp_flags = m[35:32];
    e.owner  = exp_owner;
    e.result = m[31:0];
    e.rflags = m[35:32];
    e.flags  = exp_flags;
    sb_q.push_back(e);
    @(posedge i_CLK); #1;
    i_ReqValid[exp_owner] = 1'b0;
    @(negedge i_CLK);
    check_eq("exec_rspvalid", o_RspValid, 0);
    check_eq("exec_reqready", o_ReqReady, 0);
    @(posedge i_CLK); #1;
    e = sb_q[0];
    for (int k = 0; k < hold; k++) begin
      i_RspReady = ~onehot(exp_owner);
      @(negedge i_CLK);
      check_eq("hold_rspvalid", o_RspValid, onehot(e.owner));
      check_eq("hold_result", o_RspResult, e.result);
      check_eq("hold_rspflags", o_RspFlags, e.rflags);
      check_eq("hold_reqready", o_ReqReady, 0);
      @(posedge i_CLK); #1;
    end
    i_RspReady = onehot(exp_owner);
    @(negedge i_CLK);
    e = sb_q.pop_front();
    check_eq("rsp_valid", o_RspValid, onehot(e.owner));
    check_eq("rsp_result", o_RspResult, e.result);
    check_eq("rsp_flags", o_RspFlags, e.rflags);
    check_eq("arch_flags", o_Flags, e.flags);
    $display("txn req%0d result=%08h nzcv=%04b flags=%04b hold=%0d",
             e.owner, o_RspResult, o_RspFlags, o_Flags, hold);
    @(posedge i_CLK); #1;
    i_RspReady = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_reqready"}, o_ReqReady, 0);
    check_eq({tag, "_rspvalid"}, o_RspValid, 0);
    check_eq({tag, "_result"}, o_RspResult, 0);
    check_eq({tag, "_rspflags"}, o_RspFlags, 0);
    check_eq({tag, "_flags"}, o_Flags, FLAGS_RST);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge i_CLK);
    check_reset_outputs("por");
    i_RST_N = 1'b1;
    @(posedge i_CLK); #1;

    // Contention straight after reset: req0 first, then req1 with backpressure.
    issue(0, ALU_ADD, 32'd5, 32'd7, 1'b1);
    issue(1, ALU_SUB, 32'd3, 32'd3, 1'b0);
    serve(0, 0);
    issue(0, ALU_OR, 32'd0, 32'd0, 1'b0);
    serve(1, 4);
    serve(0, 0);

    // Pointer now at req1; req0 re-requesting must lose.
    issue(0, ALU_AND, 32'hF0F0_0000, 32'hFF00_0000, 1'b1);
    issue(1, ALU_ADD, 32'h7FFF_FFFF, 32'd1, 1'b1);
    serve(1, 0);
    serve(0, 0);

    // Reset while the operation is in EXEC.
    issue(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
    @(negedge i_CLK);
    check_eq("rst_grant", o_ReqReady, onehot(1));
    @(posedge i_CLK); #1;
    i_ReqValid = '0;
    #2;
    i_RST_N = 1'b0;
    #1;
    check_reset_outputs("mid");
    exp_flags = FLAGS_RST;
    sb_q.delete();
    @(posedge i_CLK); #1;
    check_eq("mid_after_edge_rspvalid", o_RspValid, 0);
    @(negedge i_CLK);
    i_RST_N = 1'b1;
    @(posedge i_CLK); #1;
    issue(0, ALU_SUB, 32'd1, 32'd2, 1'b1);
    issue(1, ALU_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
    serve(0, 0);
    serve(1, 1);

    check_eq("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
